// File: rtl/iter_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : iter_arb_if
// Description : Bundle of the request/grant handshake and datapath control
//               signals between two requesters and the iterative arbiter.
//   req   : per-requester level request (requester side drives)
//   grant : one-hot owner of the shared datapath
//   done  : one-cycle completion pulse to the owner
//   s     : datapath mux select (0 = load operands, 1 = feedback)
//   en1   : working-register enable
//   en2   : result-register enable
//   iter  : current RUN iteration index
//   busy  : arbiter not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface iter_arb_if #(
  parameter int CW = 6
) ();
  logic [1:0]    req;
  logic [1:0]    grant;
  logic [1:0]    done;
  logic          s;
  logic          en1;
  logic          en2;
  logic [CW-1:0] iter;
  logic          busy;

  // Requester / environment side
  modport master (
    output req,
    input  grant, done, s, en1, en2, iter, busy
  );

  // Arbiter side
  modport slave (
    input  req,
    output grant, done, s, en1, en2, iter, busy
  );
endinterface
`default_nettype wire

// File: rtl/iter_arb.sv
`default_nettype none
// ============================================================================
// Module      : iter_arb
// Description : Two-requester round-robin arbiter that owns a shared iterative
//               datapath. A granted job runs LOAD -> RUN (N_ITER cycles) ->
//               DONE -> RELEASE, then returns to IDLE once the owner drops req.
//   clk   : sole clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : iter_arb_if slave modport (req in; grant, done, s, en1, en2,
//           iter, busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module iter_arb #(
  parameter int N_ITER = 64,
  parameter int CW     = $clog2(N_ITER)
) (
  input  wire logic   clk,
  input  wire logic   reset,
  iter_arb_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam logic [CW-1:0] C_LAST = CW'(N_ITER - 1);

  state_t        state_q;
  logic          owner_q;
  logic          ptr_q;
  logic [CW-1:0] iter_q;
  logic          owner_d;
  logic          own_req;

  // Single requester wins outright; on contention the pointer decides.
  assign owner_d = (bus.req == 2'b11) ? ptr_q : bus.req[1];
  assign own_req = bus.req[owner_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          iter_q <= '0;
          if (bus.req != 2'b00) begin
            owner_q <= owner_d;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          iter_q <= '0;
          if (!own_req) begin
            // Abort: drop the job silently, hand priority to the other side.
            state_q <= ST_IDLE;
            ptr_q   <= ~owner_q;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!own_req) begin
            state_q <= ST_IDLE;
            ptr_q   <= ~owner_q;
            iter_q  <= '0;
          end else if (iter_q == C_LAST) begin
            // Last iteration: iter holds so it never wraps within a job.
            state_q <= ST_DONE;
          end else begin
            iter_q <= iter_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!own_req) begin
            state_q <= ST_IDLE;
            ptr_q   <= ~owner_q;
            iter_q  <= '0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          iter_q  <= '0;
        end
      endcase
    end
  end

  // Moore output decode; unknown encodings fall through to all-zero.
  always_comb begin
    bus.grant = 2'b00;
    bus.done  = 2'b00;
    bus.s     = 1'b0;
    bus.en1   = 1'b0;
    bus.en2   = 1'b0;
    bus.iter  = '0;
    bus.busy  = 1'b0;
    case (state_q)
      ST_IDLE: begin
      end
      ST_LOAD: begin
        bus.grant = owner_q ? 2'b10 : 2'b01;
        bus.en1   = 1'b1;
        bus.iter  = iter_q;
        bus.busy  = 1'b1;
      end
      ST_RUN: begin
        bus.grant = owner_q ? 2'b10 : 2'b01;
        bus.s     = 1'b1;
        bus.en1   = 1'b1;
        bus.iter  = iter_q;
        bus.busy  = 1'b1;
      end
      ST_DONE: begin
        bus.grant = owner_q ? 2'b10 : 2'b01;
        bus.done  = owner_q ? 2'b10 : 2'b01;
        bus.en2   = 1'b1;
        bus.iter  = iter_q;
        bus.busy  = 1'b1;
      end
      ST_RELEASE: begin
        bus.grant = owner_q ? 2'b10 : 2'b01;
        bus.iter  = iter_q;
        bus.busy  = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_iter_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_iter_arb
// Description : Directed self-checking bench for iter_arb. One instance with
//               N_ITER=4 covers arbitration, abort, reset and RELEASE hold;
//               a second with N_ITER=64 covers a full-length job.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iter_arb;

  localparam int ST_IDLE = 0;
  localparam int ST_LOAD = 1;
  localparam int ST_RUN  = 2;
  localparam int ST_DONE = 3;
  localparam int ST_REL  = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  iter_arb_if #(.CW(2)) bus   ();
  iter_arb_if #(.CW(6)) bus64 ();

  iter_arb #(.N_ITER(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  iter_arb #(.N_ITER(64)) dut64 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs for each state, packed {busy,grant,done,s,en1,en2,iter}.
  task automatic expect_st(input string tag, input int st, input logic [1:0] g, input logic [1:0] it);
    logic [9:0] exp;
    logic [9:0] got;
    case (st)
      ST_LOAD: exp = {1'b1, g, 2'b00, 3'b010, it};
      ST_RUN:  exp = {1'b1, g, 2'b00, 3'b110, it};
      ST_DONE: exp = {1'b1, g, g,     3'b001, it};
      ST_REL:  exp = {1'b1, g, 2'b00, 3'b000, it};
      default: exp = 10'd0;
    endcase
    got = {bus.busy, bus.grant, bus.done, bus.s, bus.en1, bus.en2, bus.iter};
    check_eq(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    int  s_cnt;
    int  done_cyc;
    bit  seen;
    logic [5:0] last_it;
    logic [1:0] done_val;
    logic       en2_at_done;

    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    bus.req  = 2'b00;
    bus64.req = 2'b00;
    #1;
    expect_st("reset_state", ST_IDLE, 2'b00, 2'd0);
    check_eq("reset_state64", 32'({bus64.busy, bus64.grant, bus64.iter}), 32'd0);
    step();
    step();
    reset = 1'b1;

    // Single job, owner 0, release at cycle 8.
    bus.req = 2'b01;
    expect_st("j1_c0_idle", ST_IDLE, 2'b00, 2'd0);
    step();
    expect_st("j1_c1_load", ST_LOAD, 2'b01, 2'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_st($sformatf("j1_run%0d", i), ST_RUN, 2'b01, 2'(i));
    end
    step();
    expect_st("j1_c6_done", ST_DONE, 2'b01, 2'd3);
    step();
    expect_st("j1_c7_rel", ST_REL, 2'b01, 2'd3);
    step();
    expect_st("j1_c8_rel", ST_REL, 2'b01, 2'd3);
    bus.req = 2'b00;
    step();
    expect_st("j1_c9_idle", ST_IDLE, 2'b00, 2'd0);

    // Contention right after reset: 0 first, then 1, then 0 again.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    bus.req = 2'b11;
    step();
    expect_st("rr_load0", ST_LOAD, 2'b01, 2'd0);
    for (int i = 0; i < 4; i++) step();
    step();
    expect_st("rr_done0", ST_DONE, 2'b01, 2'd3);
    step();
    expect_st("rr_rel0", ST_REL, 2'b01, 2'd3);
    bus.req = 2'b10;
    step();
    expect_st("rr_gap_idle", ST_IDLE, 2'b00, 2'd0);
    step();
    expect_st("rr_load1", ST_LOAD, 2'b10, 2'd0);
    for (int i = 0; i < 4; i++) step();
    step();
    expect_st("rr_done1", ST_DONE, 2'b10, 2'd3);
    step();
    expect_st("rr_rel1", ST_REL, 2'b10, 2'd3);
    bus.req = 2'b00;
    step();
    expect_st("rr_idle1", ST_IDLE, 2'b00, 2'd0);
    bus.req = 2'b11;
    step();
    expect_st("rr_load0_again", ST_LOAD, 2'b01, 2'd0);

    // Abort: owner 0 drops req on 2nd RUN cycle.
    step();
    expect_st("ab_run0", ST_RUN, 2'b01, 2'd0);
    step();
    expect_st("ab_run1", ST_RUN, 2'b01, 2'd1);
    bus.req = 2'b10;
    step();
    expect_st("ab_idle", ST_IDLE, 2'b00, 2'd0);
    bus.req = 2'b11;
    step();
    expect_st("ab_ptr_load1", ST_LOAD, 2'b10, 2'd0);

    // Reset pulse on the 3rd RUN cycle.
    step();
    step();
    step();
    expect_st("rs_run2", ST_RUN, 2'b10, 2'd2);
    reset = 1'b0;
    #1;
    expect_st("rs_immediate", ST_IDLE, 2'b00, 2'd0);
    step();
    expect_st("rs_held", ST_IDLE, 2'b00, 2'd0);
    reset = 1'b1;
    step();
    expect_st("rs_fresh_load", ST_LOAD, 2'b01, 2'd0);

    // Abort in LOAD, then owner 1 holds req 5 cycles after done.
    bus.req = 2'b00;
    step();
    expect_st("hd_abort_idle", ST_IDLE, 2'b00, 2'd0);
    bus.req = 2'b10;
    step();
    expect_st("hd_load", ST_LOAD, 2'b10, 2'd0);
    for (int i = 0; i < 4; i++) step();
    step();
    expect_st("hd_done", ST_DONE, 2'b10, 2'd3);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_st($sformatf("hd_rel%0d", i), ST_REL, 2'b10, 2'd3);
    end
    bus.req = 2'b00;
    step();
    expect_st("hd_idle", ST_IDLE, 2'b00, 2'd0);

    // Full-length job on the N_ITER=64 instance.
    s_cnt       = 0;
    seen        = 1'b0;
    done_cyc    = 0;
    last_it     = '0;
    done_val    = 2'b00;
    en2_at_done = 1'b0;
    bus64.req = 2'b01;
    for (int k = 1; k <= 200 && !seen; k++) begin
      step();
      if (bus64.s) s_cnt++;
      if (bus64.done != 2'b00) begin
        seen        = 1'b1;
        done_cyc    = k;
        done_val    = bus64.done;
        en2_at_done = bus64.en2;
      end else begin
        last_it = bus64.iter;
      end
    end
    check_eq("n64_done_seen", 32'(seen), 32'd1);
    check_eq("n64_s_cycles", 32'(s_cnt), 32'd64);
    check_eq("n64_done_cycle", 32'(done_cyc), 32'd66);
    check_eq("n64_done_val", 32'(done_val), 32'd1);
    check_eq("n64_en2", 32'(en2_at_done), 32'd1);
    check_eq("n64_last_iter", 32'(last_it), 32'd63);
    bus64.req = 2'b00;
    step();
    step();
    check_eq("n64_idle", 32'({bus64.busy, bus64.grant, bus64.iter}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
